stopwatch_time_counter: RTL and testbench

Datapath stage directly downstream of the stopwatch control FSM. It consumes `init_regs` and `count_enabled` and keeps elapsed time as four BCD digits, SS.cc: seconds 00–59 and centiseconds 00–99. It also implements the split (lap-freeze) display latch. Its outputs drive the 7-segment display mux.

---
 rtl/stopwatch_time_counter.sv | 120 ++++++++++++
 tb/tb_stopwatch_time_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch SS.cc BCD time base with split (lap-freeze) display latch; display lags live by 1 clock.
// No backpressure: counts whenever count_enabled is high; all outputs registered.
module stopwatch_time_counter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_regs,
  input  logic       count_enabled,
  input  logic       split,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_cs_tens,
  output logic [3:0] disp_cs_ones,
  output logic       frozen,
  output logic       wrap
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } time_t;

  logic [PW-1:0] pre_q, pre_d;
  time_t         live_q, live_d;
  time_t         disp_q, disp_d;
  logic          frozen_q, frozen_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  always_comb begin
    pre_d    = pre_q;
    live_d   = live_q;
    disp_d   = disp_q;
    frozen_d = frozen_q;
    wrap_d   = 1'b0;
    tick     = 1'b0;

    if (init_regs) begin
      pre_d    = '0;
      live_d   = '0;
      disp_d   = '0;
      frozen_d = 1'b0;
    end else begin
      if (count_enabled) begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          tick  = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end

      // Ripple carry; >= comparisons force any stray non-BCD digit back to 0.
      if (tick) begin
        if (live_q.cs_ones < 4'd9) begin
          live_d.cs_ones = live_q.cs_ones + 4'd1;
        end else begin
          live_d.cs_ones = 4'd0;
          if (live_q.cs_tens < 4'd9) begin
            live_d.cs_tens = live_q.cs_tens + 4'd1;
          end else begin
            live_d.cs_tens = 4'd0;
            if (live_q.sec_ones < 4'd9) begin
              live_d.sec_ones = live_q.sec_ones + 4'd1;
            end else begin
              live_d.sec_ones = 4'd0;
              if (live_q.sec_tens < 4'd5) begin
                live_d.sec_tens = live_q.sec_tens + 4'd1;
              end else begin
                live_d.sec_tens = 4'd0;
                wrap_d          = 1'b1;
              end
            end
          end
        end
      end

      if (split) begin
        frozen_d = ~frozen_q;
      end

      // Display follows the pre-edge live value, so a freeze keeps what is on screen now.
      if (!frozen_d) begin
        disp_d = live_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      live_q   <= '0;
      disp_q   <= '0;
      frozen_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      live_q   <= live_d;
      disp_q   <= disp_d;
      frozen_q <= frozen_d;
      wrap_q   <= wrap_d;
    end
  end

  assign disp_sec_tens = disp_q.sec_tens;
  assign disp_sec_ones = disp_q.sec_ones;
  assign disp_cs_tens  = disp_q.cs_tens;
  assign disp_cs_ones  = disp_q.cs_ones;
  assign frozen        = frozen_q;
  assign wrap          = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter at DIV=4: constant vector table, hand corner sequences,
// and a randomized run checked against an arithmetic (total-centisecond) model.
module tb_stopwatch_time_counter;

  localparam int DIV = 4;

  logic clk;
  logic reset;
  logic init_regs;
  logic count_enabled;
  logic split;
  logic [3:0] disp_sec_tens, disp_sec_ones, disp_cs_tens, disp_cs_ones;
  logic frozen;
  logic wrap;
  logic [15:0] dut_disp;

  int checks = 0;
  int errors = 0;

  // Model state: live and display as integer centiseconds 0..5999.
  int m_pre, m_live, m_disp;
  bit m_frozen, m_wrap;

  stopwatch_time_counter #(.CLK_FREQ_HZ(4), .TICK_HZ(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .split         (split),
    .disp_sec_tens (disp_sec_tens),
    .disp_sec_ones (disp_sec_ones),
    .disp_cs_tens  (disp_cs_tens),
    .disp_cs_ones  (disp_cs_ones),
    .frozen        (frozen),
    .wrap          (wrap)
  );

  assign dut_disp = {disp_sec_tens, disp_sec_ones, disp_cs_tens, disp_cs_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int s, c;
    s = v / 100;
    c = v % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_clear();
    m_pre = 0; m_live = 0; m_disp = 0; m_frozen = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit ini, input bit ce, input bit sp);
    bit tick;
    bit nf;
    if (ini) begin
      model_clear();
    end else begin
      tick = 0;
      if (ce) begin
        m_pre = m_pre + 1;
        if (m_pre == DIV) begin
          m_pre = 0;
          tick  = 1;
        end
      end
      nf = sp ? !m_frozen : m_frozen;
      if (!nf) m_disp = m_live;
      m_wrap   = tick && (m_live == 5999);
      if (tick) m_live = (m_live + 1) % 6000;
      m_frozen = nf;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, then settle 1 unit past the edge.
  task automatic step(input bit ini, input bit ce, input bit sp);
    init_regs = ini; count_enabled = ce; split = sp;
    @(posedge clk);
    model_step(ini, ce, sp);
    #1;
  endtask

  typedef struct {
    bit          ini;
    bit          ce;
    bit          sp;
    int          n;
    logic [15:0] exp_disp;
    bit          exp_frz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit ri, rc, rs;

    vecs.push_back('{1, 0, 0,  2, 16'h0000, 0});
    vecs.push_back('{0, 1, 0,  4, 16'h0000, 0}); // first tick on 4th edge, display lags
    vecs.push_back('{0, 1, 0,  2, 16'h0001, 0});
    vecs.push_back('{0, 0, 0, 10, 16'h0001, 0}); // pause keeps partial prescale
    vecs.push_back('{0, 1, 0,  1, 16'h0001, 0});
    vecs.push_back('{0, 1, 0,  1, 16'h0001, 0}); // tick after exactly 2 resumed edges
    vecs.push_back('{0, 0, 0,  1, 16'h0002, 0});
    vecs.push_back('{0, 1, 0,  4, 16'h0002, 0});
    vecs.push_back('{0, 0, 0,  1, 16'h0003, 0});
    vecs.push_back('{0, 1, 1,  1, 16'h0003, 1}); // freeze at 00.03
    vecs.push_back('{0, 1, 0, 15, 16'h0003, 1}); // live reaches 00.07
    vecs.push_back('{0, 0, 0,  1, 16'h0003, 1});
    vecs.push_back('{0, 0, 1,  1, 16'h0007, 0}); // unfreeze shows live
    vecs.push_back('{1, 1, 1,  1, 16'h0000, 0}); // clear beats count and split
    vecs.push_back('{0, 1, 0,  4, 16'h0000, 0});
    vecs.push_back('{0, 0, 0,  1, 16'h0001, 0}); // prescaler was 0 after clear
    vecs.push_back('{1, 0, 0,  1, 16'h0000, 0});
    vecs.push_back('{0, 1, 0, 40, 16'h0009, 0});
    vecs.push_back('{0, 0, 0,  1, 16'h0010, 0}); // carry into cs_tens
    vecs.push_back('{0, 1, 0,  3, 16'h0010, 0});
    vecs.push_back('{0, 1, 1,  1, 16'h0010, 1}); // split on tick edge holds pre-tick value
    vecs.push_back('{0, 0, 1,  1, 16'h0011, 0});

    reset = 1'b0; init_regs = 1'b0; count_enabled = 1'b0; split = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_disp", dut_disp, 16'h0000);
    check("reset_frozen", {15'd0, frozen}, 16'd0);
    check("reset_wrap", {15'd0, wrap}, 16'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i].ini, vecs[i].ce, vecs[i].sp);
      check($sformatf("vec%0d_disp", i), dut_disp, vecs[i].exp_disp);
      check($sformatf("vec%0d_frozen", i), {15'd0, frozen}, {15'd0, vecs[i].exp_frz});
    end

    // Async reset mid-count while frozen, then restart from a zero prescaler.
    step(1, 0, 0);
    repeat (6) step(0, 1, 0);
    step(0, 1, 1);
    check("pre_areset_frozen", {15'd0, frozen}, 16'd1);
    reset = 1'b0;
    #2;
    check("areset_disp_now", dut_disp, 16'h0000);
    check("areset_frozen_now", {15'd0, frozen}, 16'd0);
    init_regs = 1'b0; count_enabled = 1'b1; split = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    repeat (4) step(0, 1, 0);
    check("restart_no_early_tick", dut_disp, 16'h0000);
    step(0, 0, 0);
    check("restart_first_tick", dut_disp, 16'h0001);

    // Full wrap from 59.99.
    step(1, 0, 0);
    repeat (5999 * DIV) step(0, 1, 0);
    step(0, 0, 0);
    check("preload_5999", dut_disp, 16'h5999);
    check("preload_wrap_low", {15'd0, wrap}, 16'd0);
    repeat (DIV - 1) step(0, 1, 0);
    check("wrap_not_yet", {15'd0, wrap}, 16'd0);
    step(0, 1, 0);
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    check("wrap_disp_lag", dut_disp, 16'h5999);
    step(0, 0, 0);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    check("wrap_disp_zero", dut_disp, 16'h0000);

    // Randomized run starting near rollover, compared with the model every edge.
    step(1, 0, 0);
    repeat (5950 * DIV) step(0, 1, 0);
    for (int n = 0; n < 6000; n++) begin
      ri = ($urandom_range(0, 2047) == 0);
      rc = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0);
      step(ri, rc, rs);
      check("rand_disp", dut_disp, to_bcd(m_disp));
      check("rand_frozen", {15'd0, frozen}, {15'd0, m_frozen});
      check("rand_wrap", {15'd0, wrap}, {15'd0, m_wrap});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
